// File: rtl/weight_load_ctrl_if.sv
// DDR-to-weight-loader byte stream.
// Valid/ready handshake; the DDR side drives data and valid.
interface weight_load_ctrl_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/weight_load_ctrl.sv
// Weight FIFO sequencer: column-major fill from DDR, then
// lock-step drain into the MMU with en_load_weight/weight_row.
module weight_load_ctrl #(
    parameter int N_COLS = 4,
    parameter int DEPTH  = 4,
    parameter int DW     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    weight_load_ctrl_if.slave        ddr,
    output logic [N_COLS-1:0]        fifo_push,
    output logic [DW-1:0]            fifo_data,
    output logic [N_COLS-1:0]        fifo_pop,
    output logic                     fifo_clr,
    output logic                     en_load_weight,
    output logic [$clog2(DEPTH)-1:0] weight_row
);
    localparam int RW  = $clog2(DEPTH);
    localparam int CW  = $clog2(N_COLS);
    localparam int DCW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } state_t;

    state_t         state;
    logic [RW-1:0]  row_cnt;
    logic [CW-1:0]  col_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           xfer;

    assign ddr.in_ready = (state == FILL);
    assign xfer         = ddr.in_valid & ddr.in_ready;
    assign fifo_data    = ddr.in_data;

    always_comb begin
        fifo_push = '0;
        for (int c = 0; c < N_COLS; c++) begin
            if (col_cnt == CW'(c)) fifo_push[c] = xfer;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            row_cnt        <= '0;
            col_cnt        <= '0;
            drain_cnt      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fifo_pop       <= '0;
            fifo_clr       <= 1'b1;
            en_load_weight <= 1'b0;
            weight_row     <= '0;
        end else begin
            fifo_clr <= 1'b0;
            done     <= 1'b0;
            if (abort && state != IDLE) begin
                // Clear realigns all FIFO pointers, incl. a coincident push
                state          <= IDLE;
                row_cnt        <= '0;
                col_cnt        <= '0;
                drain_cnt      <= '0;
                busy           <= 1'b0;
                fifo_pop       <= '0;
                fifo_clr       <= 1'b1;
                en_load_weight <= 1'b0;
                weight_row     <= '0;
            end else begin
                en_load_weight <= fifo_pop[0];
                weight_row     <= en_load_weight ? weight_row + RW'(1) : '0;
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= FILL;
                            busy    <= 1'b1;
                            row_cnt <= '0;
                            col_cnt <= '0;
                        end
                    end
                    FILL: begin
                        if (xfer) begin
                            if (row_cnt == RW'(DEPTH - 1)) begin
                                row_cnt <= '0;
                                if (col_cnt == CW'(N_COLS - 1)) begin
                                    col_cnt   <= '0;
                                    state     <= DRAIN;
                                    fifo_pop  <= '1;
                                    drain_cnt <= '0;
                                end else begin
                                    col_cnt <= col_cnt + CW'(1);
                                end
                            end else begin
                                row_cnt <= row_cnt + RW'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        // One extra cycle lets the last popped row reach the MMU
                        if (drain_cnt == DCW'(DEPTH)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            fifo_pop <= '0;
                        end else begin
                            drain_cnt <= drain_cnt + DCW'(1);
                            fifo_pop  <= (drain_cnt < DCW'(DEPTH - 1)) ?
                                         '1 : '0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_weight_load_ctrl.sv
// Random + directed bench: tile-level reference model and a
// behavioural column-FIFO array checking what the MMU receives.
module tb_weight_load_ctrl;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int DW = 8;
    localparam int TILE = N * D;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic           busy;
    logic           done;
    logic [N-1:0]   fifo_push;
    logic [DW-1:0]  fifo_data;
    logic [N-1:0]   fifo_pop;
    logic           fifo_clr;
    logic           en_load_weight;
    logic [1:0]     weight_row;

    weight_load_ctrl_if #(.DW(DW)) ddr ();

    weight_load_ctrl #(.N_COLS(N), .DEPTH(D), .DW(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .ddr            (ddr.slave),
        .fifo_push      (fifo_push),
        .fifo_data      (fifo_data),
        .fifo_pop       (fifo_pop),
        .fifo_clr       (fifo_clr),
        .en_load_weight (en_load_weight),
        .weight_row     (weight_row)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural column FIFOs driven by the DUT's control outputs
    logic [DW-1:0] fmem [N][D];
    int            wp [N];
    int            rp [N];
    logic [DW-1:0] fout [N];

    always @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (fifo_clr) begin
                wp[c] <= 0;
                rp[c] <= 0;
            end else begin
                if (fifo_push[c]) begin
                    fmem[c][wp[c]] <= fifo_data;
                    wp[c] <= (wp[c] + 1) % D;
                end
                if (fifo_pop[c]) begin
                    fout[c] <= fmem[c][rp[c]];
                    rp[c] <= (rp[c] + 1) % D;
                end
            end
        end
    end

    int dut_dones = 0;
    always @(posedge clk) if (rst_n && done) dut_dones <= dut_dones + 1;

    // Reference model: tile progress as byte count / drain cycle index
    int          m_mode = M_IDLE;
    int          m_k = 0;
    int          m_t = 0;
    bit          m_clr = 1'b1;
    int          m_dones = 0;
    logic [7:0]  tile [TILE];

    task automatic cyc(input logic s, input logic a, input logic v,
                       input logic [7:0] d);
        logic [31:0] e_push;
        logic        e_en;
        logic [31:0] got_mmu;
        logic [31:0] exp_mmu;
        start        = s;
        abort        = a;
        ddr.in_valid = v;
        ddr.in_data  = d;
        #1;
        e_push = (m_mode == M_FILL && v) ? (32'd1 << (m_k / D)) : 32'd0;
        e_en   = (m_mode == M_DRAIN && m_t >= 1);
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
        chk("done", 32'(done), 32'(m_mode == M_DONE));
        chk("in_ready", 32'(ddr.in_ready), 32'(m_mode == M_FILL));
        chk("push", 32'(fifo_push), e_push);
        chk("pop", 32'(fifo_pop),
            (m_mode == M_DRAIN && m_t < D) ? 32'hF : 32'h0);
        chk("en_load", 32'(en_load_weight), 32'(e_en));
        chk("row", 32'(weight_row), e_en ? 32'(m_t - 1) : 32'd0);
        chk("clr", 32'(fifo_clr), 32'(m_clr));
        chk("fifo_data", 32'(fifo_data), 32'(d));
        if (e_en) begin
            got_mmu = '0;
            exp_mmu = '0;
            for (int c = 0; c < N; c++) begin
                got_mmu[8*c +: 8] = fout[c];
                exp_mmu[8*c +: 8] = tile[c * D + m_t - 1];
            end
            chk("mmu_row", got_mmu, exp_mmu);
        end
        m_clr = (m_mode != M_IDLE) && a;
        if (m_mode != M_IDLE && a) begin
            m_mode = M_IDLE;
            m_k    = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (s) begin
                    m_mode = M_FILL;
                    m_k    = 0;
                end
                M_FILL: if (v) begin
                    tile[m_k] = d;
                    m_k++;
                    if (m_k == TILE) begin
                        m_mode = M_DRAIN;
                        m_t    = 0;
                    end
                end
                M_DRAIN: begin
                    if (m_t == D) begin
                        m_mode = M_DONE;
                        m_dones++;
                    end else m_t++;
                end
                default: m_mode = M_IDLE;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        ddr.in_valid = 1'b0;
        ddr.in_data  = '0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(ddr.in_ready), 0);
        chk("rst_push", 32'(fifo_push), 0);
        chk("rst_pop", 32'(fifo_pop), 0);
        chk("rst_en", 32'(en_load_weight), 0);
        chk("rst_row", 32'(weight_row), 0);
        chk("rst_clr", 32'(fifo_clr), 1);
        m_mode = M_IDLE;
        m_k    = 0;
        m_clr  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'($urandom_range(255)));
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        // Straight fill 0x00..0x0F then drain
        cyc(1, 0, 0, 0);
        for (int i = 0; i < TILE; i++) cyc(0, 0, 1, 8'(i));
        idle(8);

        // Stalls 1,0,0 pattern
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 100 && m_mode == M_FILL; i++)
            cyc(0, 0, (i % 3) == 0, 8'($urandom_range(255)));
        idle(8);

        // Abort after 6 bytes, coincident with a 7th push
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'($urandom_range(255)));
        cyc(0, 1, 1, 8'hEE);
        idle(2);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < TILE; i++) cyc(0, 0, 1, 8'(8'h80 + i));
        idle(8);

        // Start held high throughout
        for (int i = 0; i < 50; i++) cyc(1, 0, 1, 8'($urandom_range(255)));
        idle(30);

        // Abort during drain and during done
        cyc(1, 0, 0, 0);
        for (int i = 0; i < TILE; i++) cyc(0, 0, 1, 8'($urandom_range(255)));
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < TILE; i++) cyc(0, 0, 1, 8'($urandom_range(255)));
        idle(5);
        cyc(0, 1, 0, 0);
        idle(3);

        // Reset mid-FILL
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'($urandom_range(255)));
        do_reset();
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(7) == 0), ($urandom_range(39) == 0),
                ($urandom_range(3) != 0), 8'($urandom_range(255)));
        idle(30);

        chk("done_count", 32'(dut_dones), 32'(m_dones));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
